// File: rtl/fetch_cycle_pkg.sv
// Shared fetch-stage definitions:
// bubble encoding, reset PC, FSM states, IF/ID record.
package fetch_cycle_pkg;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef logic [1:0] fstate_t;

  localparam fstate_t S_FETCH = 2'd0;
  localparam fstate_t S_KILL  = 2'd1;
  localparam fstate_t S_HOLD  = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic if_id_t bubble(
    input logic [31:0] pc,
    input logic [31:0] nop
  );
    bubble = '{
      instr:    nop,
      pc:       pc,
      pc_plus4: pc + 32'd4,
      valid:    1'b0
    };
  endfunction

endpackage

// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/response port
// between the fetch stage and instruction memory.
interface fetch_cycle_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_cycle_if_id_reg.sv
// IF/ID pipeline register.
// Priority: reset, flush, hold, load.
module if_id_reg
  import fetch_cycle_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // Flush turns the incoming slot into a bubble;
  // its PC fields still follow the load source.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '{
        instr:    NOP_INSTR,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0004,
        valid:    1'b0
      };
    end else if (flush) begin
      q <= '{
        instr:    NOP_INSTR,
        pc:       d.pc,
        pc_plus4: d.pc_plus4,
        valid:    1'b0
      };
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: PC, imem port,
// redirect/stall handling and IF/ID register.
module fetch_cycle
  import fetch_cycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallF,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_cycle_if.master imem,
  output logic [31:0]   instructionF,
  output logic [31:0]   PCF,
  output logic [31:0]   PCPlus4F,
  output logic          validF
);

  fstate_t     state;
  fstate_t     state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] pc_plus4;
  logic [31:0] req_addr;
  logic [31:0] req_addr_n;
  logic [31:0] target;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_load;
  logic        st_fetch;
  logic        st_kill;
  logic        st_hold;
  if_id_t      id_d;
  if_id_t      id_q;

  assign st_fetch = (state == S_FETCH);
  assign st_kill  = (state == S_KILL);
  assign st_hold  = (state == S_HOLD);
  assign target   = {PCTargetE[31:2], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  // KILL keeps the orphaned address on the bus
  // until its response drains.
  always_comb begin
    imem.imem_req  = reset & (st_fetch | st_kill);
    imem.imem_addr = st_kill ? req_addr : pc;
  end

  // Next-state, next-PC and IF/ID source selection.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    buf_load   = 1'b0;
    id_d       = bubble(pc, NOP_INSTR);
    unique case (1'b1)
      st_fetch: begin
        req_addr_n = pc;
        if (PCSrcE) begin
          pc_n = target;
          if (!imem.imem_ready) begin
            state_n = S_KILL;
          end
        end else if (imem.imem_ready && StallF) begin
          buf_load = 1'b1;
          state_n  = S_HOLD;
        end else if (imem.imem_ready) begin
          id_d = '{
            instr:    imem.imem_rdata,
            pc:       pc,
            pc_plus4: pc_plus4,
            valid:    1'b1
          };
          pc_n = pc_plus4;
        end
      end
      st_kill: begin
        if (PCSrcE) begin
          pc_n = target;
        end
        if (imem.imem_ready) begin
          state_n = S_FETCH;
        end
      end
      st_hold: begin
        if (PCSrcE) begin
          pc_n    = target;
          state_n = S_FETCH;
        end else if (!StallF) begin
          id_d = '{
            instr:    buf_instr,
            pc:       buf_pc,
            pc_plus4: buf_pc + 32'd4,
            valid:    1'b1
          };
          pc_n    = buf_pc + 32'd4;
          state_n = S_FETCH;
        end
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  // PC, FSM state and outstanding request address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
    end
  end

  // Hold buffer: a response that arrived under stall.
  always_ff @(posedge clk) begin
    if (reset && buf_load) begin
      buf_instr <= imem.imem_rdata;
      buf_pc    <= pc;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .flush (FlushD),
    .hold  (StallF),
    .load  (1'b1),
    .d     (id_d),
    .q     (id_q)
  );

  assign instructionF = id_q.instr;
  assign PCF          = id_q.pc;
  assign PCPlus4F     = id_q.pc_plus4;
  assign validF       = id_q.valid;

endmodule

// File: tb/tb_fetch_cycle.sv
// Fetch stage bench: directed scenarios with literal
// expectations plus random traffic against a model.
module tb_fetch_cycle;
  import fetch_cycle_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] instructionF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;

  fetch_cycle_if imem ();

  fetch_cycle dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .FlushD       (FlushD),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .imem         (imem),
    .instructionF (instructionF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .validF       (validF)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: PC, an orphaned request (address still
  // owed a response), and a parked response.
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  bit          m_orphan;
  logic [31:0] m_oaddr;
  bit          m_buf;
  logic [31:0] m_binstr;
  logic [31:0] m_bpc;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  logic [31:0] e_pc4;
  bit          e_valid;
  bit          e_pin;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st,
                            input bit fl, input bit br,
                            input logic [31:0] tg,
                            input bit rdy,
                            input logic [31:0] rd);
    bit          got;
    logic [31:0] g_instr;
    logic [31:0] g_pc;
    logic [31:0] t;
    t       = tg & 32'hFFFF_FFFC;
    got     = 1'b0;
    g_instr = 32'h0;
    g_pc    = 32'h0;
    if (!r) begin
      m_known  = 1'b1;
      m_pc     = DEF_RESET_PC;
      m_orphan = 1'b0;
      m_buf    = 1'b0;
      e_instr  = DEF_NOP_INSTR;
      e_pc     = 32'h0;
      e_pc4    = 32'h4;
      e_valid  = 1'b0;
      e_pin    = 1'b1;
      return;
    end
    if (m_buf) begin
      if (br) begin
        m_buf = 1'b0;
        m_pc  = t;
      end else if (!st) begin
        got     = 1'b1;
        g_instr = m_binstr;
        g_pc    = m_bpc;
        m_pc    = m_bpc + 32'd4;
        m_buf   = 1'b0;
      end
    end else if (m_orphan) begin
      if (br) m_pc = t;
      if (rdy) m_orphan = 1'b0;
    end else if (br) begin
      if (!rdy) begin
        m_orphan = 1'b1;
        m_oaddr  = m_pc;
      end
      m_pc = t;
    end else if (rdy && st) begin
      m_buf    = 1'b1;
      m_binstr = rd;
      m_bpc    = m_pc;
    end else if (rdy) begin
      got     = 1'b1;
      g_instr = rd;
      g_pc    = m_pc;
      m_pc    = m_pc + 32'd4;
    end
    if (fl) begin
      e_instr = DEF_NOP_INSTR;
      e_valid = 1'b0;
      e_pin   = 1'b0;
    end else if (st) begin
    end else if (got) begin
      e_instr = g_instr;
      e_pc    = g_pc;
      e_pc4   = g_pc + 32'd4;
      e_valid = 1'b1;
      e_pin   = 1'b0;
    end else begin
      e_instr = DEF_NOP_INSTR;
      e_valid = 1'b0;
      e_pin   = 1'b0;
    end
  endtask

  // One clock: check IF/ID, drive, check the port,
  // advance the model, then let the edge happen.
  task automatic step(input bit r, input bit st,
                      input bit fl, input bit br,
                      input logic [31:0] tg,
                      input bit rdy);
    logic [31:0] rd;
    bit          ereq;
    @(negedge clk);
    if (m_known) begin
      chk("validF", {31'b0, validF}, {31'b0, e_valid});
      chk("instructionF", instructionF, e_instr);
      if (e_valid || e_pin) begin
        chk("PCF", PCF, e_pc);
        chk("PCPlus4F", PCPlus4F, e_pc4);
      end
    end
    reset     = r;
    StallF    = st;
    FlushD    = fl;
    PCSrcE    = br;
    PCTargetE = tg;
    rd = rdy ? mem_word(imem.imem_addr) : $urandom;
    imem.imem_ready = rdy;
    imem.imem_rdata = rd;
    #1;
    if (m_known || !r) begin
      ereq = r && !m_buf;
      chk("imem_req", {31'b0, imem.imem_req}, {31'b0, ereq});
      if (ereq) begin
        chk("imem_addr", imem.imem_addr,
            m_orphan ? m_oaddr : m_pc);
      end
    end
    model_step(r, st, fl, br, tg, rdy, rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          r;
    bit          st;
    bit          fl;
    bit          br;
    bit          rdy;
    logic [31:0] tg;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_validF", {31'b0, validF}, 32'h0);
    chk("rst_instr", instructionF, 32'h13);
    chk("rst_PCF", PCF, 32'h0);
    chk("rst_PCPlus4F", PCPlus4F, 32'h4);
    chk("rst_req", {31'b0, imem.imem_req}, 32'h0);

    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 0, 1);
      chk("zw_instr", instructionF, 32'h100 + k);
      chk("zw_PCF", PCF, 32'(4 * k));
      chk("zw_validF", {31'b0, validF}, 32'h1);
    end

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h40, 0);
    chk("kill_addr", imem.imem_addr, 32'h10);
    chk("kill_req", {31'b0, imem.imem_req}, 32'h1);
    step(1, 0, 0, 0, 0, 1);
    chk("kill_drop", {31'b0, validF}, 32'h0);
    chk("kill_next", imem.imem_addr, 32'h40);
    step(1, 0, 0, 0, 0, 1);
    chk("kill_tgt_instr", instructionF, 32'h110);
    chk("kill_tgt_PCF", PCF, 32'h40);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    chk("hold_PCF", PCF, 32'h4);
    chk("hold_instr", instructionF, 32'h101);
    chk("hold_req", {31'b0, imem.imem_req}, 32'h0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("hold_req2", {31'b0, imem.imem_req}, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("rel_instr", instructionF, 32'h102);
    chk("rel_PCF", PCF, 32'h8);
    chk("rel_PCPlus4F", PCPlus4F, 32'hC);
    chk("rel_validF", {31'b0, validF}, 32'h1);
    chk("rel_addr", imem.imem_addr, 32'hC);

    step(1, 1, 1, 0, 0, 0);
    chk("flush_instr", instructionF, 32'h13);
    chk("flush_validF", {31'b0, validF}, 32'h0);
    chk("flush_pc", imem.imem_addr, 32'hC);

    for (int g = 0; g < 3; g++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("lat_v0", {31'b0, validF}, 32'h0);
      chk("lat_addr", imem.imem_addr, 32'hC + 32'(4 * g));
      step(1, 0, 0, 0, 0, 0);
      chk("lat_v1", {31'b0, validF}, 32'h0);
      step(1, 0, 0, 0, 0, 1);
      chk("lat_v2", {31'b0, validF}, 32'h1);
      chk("lat_PCF", PCF, 32'hC + 32'(4 * g));
    end

    step(1, 0, 0, 1, 32'h80, 0);
    chk("mk_addr", imem.imem_addr, 32'h18);
    step(0, 0, 0, 0, 0, 1);
    chk("mk_req", {31'b0, imem.imem_req}, 32'h0);
    chk("mk_validF", {31'b0, validF}, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("mk_first_addr", imem.imem_addr, 32'h0);
    chk("mk_first_req", {31'b0, imem.imem_req}, 32'h1);
    step(1, 0, 0, 0, 0, 1);
    chk("mk_instr", instructionF, 32'h100);

    step(1, 0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 1);
    chk("wrap_instr", instructionF, 32'h4000_00FF);
    chk("wrap_PCF", PCF, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4F", PCPlus4F, 32'h0);
    chk("wrap_next", imem.imem_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 7) == 0);
      tg = $urandom & 32'h0000_0FFF;
      if (!r) rdy = 1'($urandom_range(0, 1));
      else if (m_buf) rdy = 1'b0;
      else rdy = ($urandom_range(0, 2) != 0);
      step(r, st, fl, br, tg, rdy);
    end
    step(1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline, directly upstream of the decode stage.
- Owns the PC register and drives a req/ready instruction-memory port.
- Absorbs variable memory latency, hazard-unit stalls, branch/jump redirects and decode flushes.
- Presents the IF/ID pipeline register (instructionF, PCF, validF) that decode consumes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven into IF/ID

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
StallF  input  1  hazard unit: hold PC and IF/ID contents
FlushD  input  1  hazard unit: replace IF/ID contents with bubble at next edge
PCSrcE  input  1  execute stage: taken branch/jump redirect
PCTargetE  input  32  redirect target (bits [1:0] ignored, forced 0)
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  input  1  response valid this cycle; imem_rdata sampled in the same cycle
imem_rdata  input  32  fetched instruction
instructionF  output  32  IF/ID instruction to decode
PCF  output  32  IF/ID PC of instructionF
PCPlus4F  output  32  IF/ID PCF+4 (JAL/JALR link value)
validF  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset=0 at an edge): PC=RESET_PC, req_addr=RESET_PC, state=FETCH, instructionF=NOP_INSTR, PCF=0, PCPlus4F=4, validF=0, hold buffer empty. imem_req=0 while reset=0.
- State FETCH: imem_req=1, imem_addr=PC; req_addr<=PC. Per-edge priority, highest first:
  1. PCSrcE=1: PC<=PCTargetE. If imem_ready=1, the response is discarded and state stays FETCH. If imem_ready=0, the outstanding request is orphaned and state goes to KILL.
  2. imem_ready=1 and StallF=1: {rdata, PC} into hold buffer, state goes to HOLD, PC unchanged.
  3. imem_ready=1: IF/ID <= {imem_rdata, PC, PC+4, valid=1}, PC<=PC+4.
  4. imem_ready=0: IF/ID <= bubble unless StallF=1, in which case IF/ID holds.
- State KILL: imem_req=1, imem_addr=req_addr (old address held stable). On imem_ready=1: discard the response and return to FETCH. A further PCSrcE in KILL overwrites PC only. IF/ID takes a bubble each cycle unless StallF=1.
- State HOLD: imem_req=0.
  - PCSrcE=1: drop the buffer, PC<=PCTargetE, state goes to FETCH.
  - StallF=0: IF/ID <= buffer {instr, pc, pc+4, 1}, PC<=buffered pc+4, state goes to FETCH.
  - Otherwise: hold.
- FlushD=1 overrides every IF/ID load at that edge: instructionF=NOP_INSTR, validF=0. PCF/PCPlus4F are don't-care but driven from the load source. FlushD does not affect PC, state or hold buffer, except that a FETCH-rule-3 load is consumed (PC still advances).
- StallF without FlushD: IF/ID unchanged.
- Latency: with zero-wait memory (imem_ready tied 1), one instruction per cycle. An instruction appears in IF/ID one edge after its ready cycle.
- Redirect penalty: the wrong-path fetch cycle produces at most one bubble per redirect. In FETCH, the redirected target is requested on the cycle after PCSrcE.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Bubbles: always validF=0 and instructionF=NOP_INSTR, so decode sees no register write.
- Mid-operation reset: abandons any outstanding request. A late imem_ready after reset must be ignored. State FETCH re-requests RESET_PC, and the memory model must tolerate this.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR encoding
  - RESET_PC default
  - fetch-state enum {FETCH, KILL, HOLD}
  - IF/ID record type {instr, pc, pc_plus4, valid}
- One natural sub-module, if_id_reg: the IF/ID register with load/flush/hold controls. Flush has priority over hold, and hold has priority over load.
- PC register, hold buffer and FSM stay in fetch_cycle.

Test Plan:
- Zero-wait, imem_ready=1, mem[i]=i+0x100, reset released at cycle 2. IF/ID shows PCF=0,4,8,... on consecutive cycles with validF=1 and instructionF=0x100,0x101,...
- Latency 2 (ready every third cycle). validF pattern 0,0,1 repeating. imem_addr stays stable across wait cycles. No PC skips.
- PCSrcE=1, PCTargetE=0x40 while a fetch at 0x10 is waiting. State goes to KILL and the 0x10 response is discarded. The next request is at 0x40. 0x10's instruction never reaches validF=1.
- StallF=1 for 3 cycles coincident with ready at PC=0x8. IF/ID holds its prior value and imem_req=0 in HOLD. On release, IF/ID={mem[2],0x8,0xC,1} and the next request is at 0xC.
- FlushD=1 with StallF=1 in the same cycle. IF/ID becomes NOP_INSTR with validF=0. PC is unchanged.
- Reset asserted mid-KILL while PC=0x80. The next cycle has imem_req=0 and validF=0. After release, the first request is at RESET_PC, and a stale imem_ready during reset is ignored.
